// File: rtl/fetch_decode_ctrl.sv
// Fetch/decode front end: owns the PC, fetches instructions over a req/valid
// handshake, and presents decoded fields to execute over valid/ready.
module fetch_decode_ctrl #(
    parameter int PC_W  = 10,
    parameter int IW    = 9,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    output logic             imem_req_o,
    output logic [PC_W-1:0]  imem_addr_o,
    input  logic [IW-1:0]    imem_rdata_i,
    input  logic             imem_valid_i,
    output logic             dec_valid_o,
    input  logic             dec_ready_i,
    output logic [2:0]       dec_op_o,
    output logic [2:0]       dec_ra_o,
    output logic [2:0]       dec_rb_o,
    output logic [PC_W-1:0]  dec_pc_o,
    input  logic             br_valid_i,
    input  logic             br_taken_i,
    output logic             done_o,
    output logic [CNT_W-1:0] retired_o
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        BR_WAIT,
        HALT
    } state_t;

    localparam logic [2:0] OP_BNE  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [IW-1:0]    ir_q, ir_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [PC_W-1:0]  brOffset;

    // Branch immediate is a 3-bit two's complement offset relative to the BNE's own PC.
    assign brOffset = {{(PC_W-3){ir_q[2]}}, ir_q[2:0]};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            ir_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        retired_d = retired_q;
        case (state_q)
            IDLE, HALT: begin
                if (start_i) begin
                    pc_d      = '0;
                    retired_d = '0;
                    state_d   = FETCH;
                end
            end
            FETCH: begin
                if (imem_valid_i) begin
                    ir_d    = imem_rdata_i;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (dec_ready_i) begin
                    if (retired_q != '1) begin
                        retired_d = retired_q + CNT_W'(1);
                    end
                    if (ir_q[8:6] == OP_HALT) begin
                        state_d = HALT;
                    end else if (ir_q[8:6] == OP_BNE) begin
                        state_d = BR_WAIT;
                    end else begin
                        pc_d    = pc_q + PC_W'(1);
                        state_d = FETCH;
                    end
                end
            end
            BR_WAIT: begin
                if (br_valid_i) begin
                    pc_d    = br_taken_i ? (pc_q + brOffset) : (pc_q + PC_W'(1));
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign imem_req_o  = (state_q == FETCH);
    assign imem_addr_o = pc_q;
    assign dec_valid_o = (state_q == DECODE);
    assign dec_op_o    = ir_q[8:6];
    assign dec_ra_o    = ir_q[5:3];
    assign dec_rb_o    = ir_q[2:0];
    assign dec_pc_o    = pc_q;
    assign done_o      = (state_q == HALT);
    assign retired_o   = retired_q;

endmodule
